// File: rtl/scan_pkg.sv
// Shared defaults and state encoding for the scan sequencer and its helper.
package scan_pkg;

  localparam int SEL_W_DEF   = 4;
  localparam int DWELL_W_DEF = 16;
  localparam int NUM_POS     = 2 ** SEL_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/scan_next_finder.sv
// Combinational search over the position mask: next enabled index after the
// current one (wrapping to the first), plus first/final enabled index <= last_sel.
module scan_next_finder
  import scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [SEL_W-1:0]      cur_idx_i,
  input  logic [2**SEL_W-1:0]   mask_i,
  input  logic [SEL_W-1:0]      last_sel_i,
  output logic [SEL_W-1:0]      next_idx_o,
  output logic [SEL_W-1:0]      first_idx_o,
  output logic [SEL_W-1:0]      final_idx_o,
  output logic                  none_enabled_o
);

  localparam int NUM = 2 ** SEL_W;

  logic             found_next_s;
  logic [SEL_W-1:0] idx_s;

  // Ascending scan: first hit sets first_idx, last hit sets final_idx.
  always_comb begin
    next_idx_o     = '0;
    first_idx_o    = '0;
    final_idx_o    = '0;
    none_enabled_o = 1'b1;
    found_next_s   = 1'b0;
    idx_s          = '0;
    for (int i = 0; i < NUM; i++) begin
      idx_s = SEL_W'(i);
      if (mask_i[i] && (idx_s <= last_sel_i)) begin
        if (none_enabled_o) begin
          first_idx_o    = idx_s;
          none_enabled_o = 1'b0;
        end else begin
          none_enabled_o = 1'b0;
        end
        final_idx_o = idx_s;
        if (!found_next_s && (idx_s > cur_idx_i)) begin
          next_idx_o   = idx_s;
          found_next_s = 1'b1;
        end else begin
          found_next_s = found_next_s;
        end
      end else begin
        found_next_s = found_next_s;
      end
    end
    if (!found_next_s) begin
      next_idx_o = first_idx_o;
    end else begin
      next_idx_o = next_idx_o;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Select-code sequencer for a one-hot decoder: dwell-timed stepping through
// positions, single or continuous frames. Optional SCAN_MASK_EN skips masked positions.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [SEL_W-1:0]     last_sel,
  input  logic [2**SEL_W-1:0]  mask,
  output logic [SEL_W-1:0]     select,
  output logic                 sel_valid,
  output logic                 step,
  output logic                 frame_done,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               step_q, step_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic [SEL_W-1:0]   last_lat_q, last_lat_d;
  logic               cont_lat_q, cont_lat_d;

  logic [SEL_W-1:0]   next_s;
  logic [SEL_W-1:0]   first_s;
  logic [SEL_W-1:0]   final_s;
  logic               none_en_s;

`ifdef SCAN_MASK_EN
  logic [2**SEL_W-1:0] mask_lat_q, mask_lat_d;
  logic [2**SEL_W-1:0] fnd_mask_s;
  logic [SEL_W-1:0]    fnd_last_s;

  // In IDLE the finder looks at the live inputs so start can pick the first position.
  assign fnd_mask_s = (state_q == IDLE) ? mask     : mask_lat_q;
  assign fnd_last_s = (state_q == IDLE) ? last_sel : last_lat_q;

  scan_next_finder #(
    .SEL_W (SEL_W)
  ) u_finder (
    .cur_idx_i      (select_q),
    .mask_i         (fnd_mask_s),
    .last_sel_i     (fnd_last_s),
    .next_idx_o     (next_s),
    .first_idx_o    (first_s),
    .final_idx_o    (final_s),
    .none_enabled_o (none_en_s)
  );
`else
  logic mask_unused_s;

  assign mask_unused_s = ^mask;
  assign next_s        = select_q + SEL_W'(1);
  assign first_s       = '0;
  assign final_s       = last_lat_q;
  assign none_en_s     = 1'b0;
`endif

  // Next-state and datapath for the IDLE/RUN controller.
  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    cnt_d       = cnt_q;
    step_d      = 1'b0;
    dwell_lat_d = dwell_lat_q;
    last_lat_d  = last_lat_q;
    cont_lat_d  = cont_lat_q;
`ifdef SCAN_MASK_EN
    mask_lat_d  = mask_lat_q;
`endif
    case (state_q)
      IDLE: begin
        select_d = '0;
        cnt_d    = '0;
        if (start && !stop && !none_en_s) begin
          state_d     = RUN;
          select_d    = first_s;
          step_d      = 1'b1;
          dwell_lat_d = dwell;
          last_lat_d  = last_sel;
          cont_lat_d  = continuous;
`ifdef SCAN_MASK_EN
          mask_lat_d  = mask;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          select_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == dwell_lat_q) begin
          cnt_d = '0;
          if (select_q != final_s) begin
            select_d = next_s;
            step_d   = 1'b1;
          end else if (cont_lat_q) begin
            select_d = first_s;
            step_d   = 1'b1;
          end else begin
            state_d  = IDLE;
            select_d = '0;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State, position, dwell counter and start-time configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      select_q    <= '0;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      dwell_lat_q <= '0;
      last_lat_q  <= '0;
      cont_lat_q  <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_lat_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      dwell_lat_q <= dwell_lat_d;
      last_lat_q  <= last_lat_d;
      cont_lat_q  <= cont_lat_d;
`ifdef SCAN_MASK_EN
      mask_lat_q  <= mask_lat_d;
`endif
    end
  end

  // frame_done depends only on registered state, so a coincident stop cannot suppress it.
  assign frame_done = (state_q == RUN) && (cnt_q == dwell_lat_q) && (select_q == final_s);
  assign select     = select_q;
  assign sel_valid  = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign step       = step_q;

endmodule
